// File: rtl/alu_requester.sv
// ALU requester: queues ALU requests in a small FIFO, issues them
// one at a time to a combinational ALU and returns registered responses.
module alu_requester #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic [2:0] alu_ctl,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_ovf,
    output logic       rsp_err,
    output logic [7:0] op_count,
    output logic       ovf_sticky,
    input  logic       clr_stats
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [10:0]   head;
    logic [2:0]    head_op;
    logic          head_legal;

    // FSM control strobes
    logic          hs;
    logic          issue;
    logic          load_err;
    logic          capture;

    // Datapath registers
    logic [2:0]    alu_ctl_q;
    logic [3:0]    alu_a_q;
    logic [3:0]    alu_b_q;
    logic          rsp_valid_q;
    logic [3:0]    rsp_result_q;
    logic          rsp_zero_q;
    logic          rsp_ovf_q;
    logic          rsp_err_q;
    logic [7:0]    op_count_q;
    logic          ovf_sticky_q;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign req_ready = !full && !rst;
    assign push      = req_valid && req_ready;

    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[10:8];

    // Legal control codes: AND, OR, ADD, SUB, SLT
    always_comb begin
        head_legal = 1'b0;
        case (head_op)
            3'b000, 3'b001, 3'b010,
            3'b110, 3'b111: head_legal = 1'b1;
            default:        head_legal = 1'b0;
        endcase
    end

    // FIFO pointer and occupancy next-state; a pop never frees room
    // for a same-cycle push because req_ready only looks at cnt_q
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO payload write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_op, req_a, req_b};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: RESP chains straight into the next entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = head_legal ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        state_d = head_legal ? S_EXEC : S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: pop/issue/error-load/capture strobes
    always_comb begin
        hs       = 1'b0;
        pop      = 1'b0;
        issue    = 1'b0;
        load_err = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pop = !empty;
            end
            S_EXEC: begin
                capture = 1'b1;
            end
            S_RESP: begin
                hs  = rsp_ready;
                pop = rsp_ready && !empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
        issue    = pop && head_legal;
        load_err = pop && !head_legal;
    end

    // ALU operand registers hold the last issued request
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctl_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
        end else if (issue) begin
            alu_ctl_q <= head[10:8];
            alu_a_q   <= head[7:4];
            alu_b_q   <= head[3:0];
        end
    end

    // Response payload: ALU capture or illegal-op error
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (capture) begin
            rsp_result_q <= alu_out;
            rsp_zero_q   <= alu_zero;
            rsp_ovf_q    <= alu_ovf;
            rsp_err_q    <= 1'b0;
        end else if (load_err) begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b1;
        end
    end

    // Response valid: raised on a new payload, dropped on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
        end else if (capture || load_err) begin
            rsp_valid_q <= 1'b1;
        end else if (hs) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Statistics; clear wins over a same-cycle update
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            op_count_q   <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            if (hs && !rsp_err_q && (op_count_q != 8'hFF)) begin
                op_count_q <= op_count_q + 8'd1;
            end
            if (capture && alu_ovf) begin
                ovf_sticky_q <= 1'b1;
            end
        end
    end

    assign alu_ctl    = alu_ctl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule
